// File: rtl/sha2_compress_core.sv
// Iterative SHA-2 compression core: one round per clock,
// on-the-fly 16-word schedule window, feed-forward on the last round.
module sha2_compress_core #(
  parameter int WORD_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   block_valid,
  output logic                   block_ready,
  input  logic [16*WORD_SIZE-1:0] block_data,
  input  logic [8*WORD_SIZE-1:0]  hash_in,
  output logic [6:0]             k_index,
  input  logic [WORD_SIZE-1:0]   k_value,
  output logic                   digest_valid,
  input  logic                   digest_ready,
  output logic [8*WORD_SIZE-1:0] digest
);

  localparam int ROUNDS = (WORD_SIZE == 64) ? 80 : 64;
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t     state;
  word_t      a, b, c, d, e, f, g, h;
  word_t      hold [8];
  word_t      w [16];
  logic [6:0] t;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_SIZE - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    if (WORD_SIZE == 64)
      return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    if (WORD_SIZE == 64)
      return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    if (WORD_SIZE == 64)
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    if (WORD_SIZE == 64)
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y,
                               input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y,
                                input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  word_t t1, t2, a_nx, e_nx, w_nx;
  logic [8*WORD_SIZE-1:0] fold;

  always_comb begin
    t1   = h + bsig1(e) + ch(e, f, g) + k_value + w[0];
    t2   = bsig0(a) + maj(a, b, c);
    a_nx = t1 + t2;
    e_nx = d + t1;
    w_nx = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    // post-round a..h folded into the chaining value
    fold = {hold[0] + a_nx, hold[1] + a,
            hold[2] + b,    hold[3] + c,
            hold[4] + e_nx, hold[5] + e,
            hold[6] + f,    hold[7] + g};
  end

  assign k_index = t;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      block_ready  <= 1'b1;
      digest_valid <= 1'b0;
      digest       <= '0;
      t            <= '0;
      a <= '0; b <= '0; c <= '0; d <= '0;
      e <= '0; f <= '0; g <= '0; h <= '0;
      for (int i = 0; i < 8; i++)
        hold[i] <= '0;
      for (int i = 0; i < 16; i++)
        w[i] <= '0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (block_valid) begin
            a <= hash_in[7*WORD_SIZE +: WORD_SIZE];
            b <= hash_in[6*WORD_SIZE +: WORD_SIZE];
            c <= hash_in[5*WORD_SIZE +: WORD_SIZE];
            d <= hash_in[4*WORD_SIZE +: WORD_SIZE];
            e <= hash_in[3*WORD_SIZE +: WORD_SIZE];
            f <= hash_in[2*WORD_SIZE +: WORD_SIZE];
            g <= hash_in[1*WORD_SIZE +: WORD_SIZE];
            h <= hash_in[0*WORD_SIZE +: WORD_SIZE];
            for (int i = 0; i < 8; i++)
              hold[i] <= hash_in[(7-i)*WORD_SIZE +: WORD_SIZE];
            for (int i = 0; i < 16; i++)
              w[i] <= block_data[(15-i)*WORD_SIZE +: WORD_SIZE];
            t           <= '0;
            block_ready <= 1'b0;
            state       <= ROUND;
          end
        end
        state == ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= e_nx;
          d <= c;
          c <= b;
          b <= a;
          a <= a_nx;
          for (int i = 0; i < 15; i++)
            w[i] <= w[i+1];
          w[15] <= w_nx;
          if (t == LAST) begin
            digest       <= fold;
            digest_valid <= 1'b1;
            t            <= '0;
            state        <= DONE;
          end else begin
            t <= t + 7'd1;
          end
        end
        state == DONE: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            block_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          digest_valid <= 1'b0;
          block_ready  <= 1'b1;
          t            <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_compress_core.sv
// Directed bench for sha2_compress_core: SHA-256 and SHA-512
// known-answer vectors, chaining, backpressure and mid-round reset.
module tb_sha2_compress_core;

  logic clk = 1'b0;
  logic rst;

  logic         bv32, br32, dv32, dr32;
  logic [511:0] bd32;
  logic [255:0] hi32, dg32;
  logic [6:0]   ki32;
  logic [31:0]  kv32;

  logic          bv64, br64, dv64, dr64;
  logic [1023:0] bd64;
  logic [511:0]  hi64, dg64;
  logic [6:0]    ki64;
  logic [63:0]   kv64;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sha2_compress_core #(.WORD_SIZE(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .block_valid  (bv32),
    .block_ready  (br32),
    .block_data   (bd32),
    .hash_in      (hi32),
    .k_index      (ki32),
    .k_value      (kv32),
    .digest_valid (dv32),
    .digest_ready (dr32),
    .digest       (dg32)
  );

  sha2_compress_core #(.WORD_SIZE(64)) u_dut64 (
    .clk          (clk),
    .rst          (rst),
    .block_valid  (bv64),
    .block_ready  (br64),
    .block_data   (bd64),
    .hash_in      (hi64),
    .k_index      (ki64),
    .k_value      (kv64),
    .digest_valid (dv64),
    .digest_ready (dr64),
    .digest       (dg64)
  );

  // SHA-512 constants; SHA-256 K[i] is the upper half of entry i
  logic [63:0] k512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd,
    64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019,
    64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe,
    64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
    64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
    64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
    64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210,
    64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
    64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
    64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
    64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
    64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910,
    64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
    64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
    64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
    64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9,
    64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207,
    64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
    64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493,
    64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
    64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  assign kv32 = (ki32 < 7'd80) ? k512[ki32][63:32] : 32'd0;
  assign kv64 = (ki64 < 7'd80) ? k512[ki64] : 64'd0;

  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] ABC_BLK256 =
    {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [1023:0] ABC_BLK512 =
    {64'h6162638000000000, 896'd0, 64'h18};
  localparam logic [255:0] ABC_DIG256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] ABC_DIG512 = {
    64'hddaf35a193617aba, 64'hcc417349ae204131,
    64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
    64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
  localparam logic [255:0] TWO_DIG256 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic get_dv(input bit wide);
    return wide ? dv64 : dv32;
  endfunction

  function automatic logic get_br(input bit wide);
    return wide ? br64 : br32;
  endfunction

  function automatic logic [6:0] get_ki(input bit wide);
    return wide ? ki64 : ki32;
  endfunction

  function automatic logic [511:0] get_dg(input bit wide);
    return wide ? dg64 : {256'd0, dg32};
  endfunction

  task automatic drive(input bit wide, input logic v,
                       input logic [1023:0] blk,
                       input logic [511:0] hin);
    if (wide) begin
      bv64 = v; bd64 = blk; hi64 = hin;
    end else begin
      bv32 = v; bd32 = blk[511:0]; hi32 = hin[255:0];
    end
  endtask

  task automatic wait_digest(input bit wide, output logic [511:0] dig);
    int cyc = 0;
    bit k_ok = 1'b1;
    while (!get_dv(wide) && cyc < 200) begin
      if (get_ki(wide) != 7'(cyc))
        k_ok = 1'b0;
      cyc++;
      @(negedge clk);
    end
    check("k_index_seq", 512'(k_ok), 512'(1'b1));
    check("latency", 512'(cyc), 512'(wide ? 80 : 64));
    dig = get_dg(wide);
  endtask

  task automatic run_block(input bit wide, input logic [1023:0] blk,
                           input logic [511:0] hin,
                           output logic [511:0] dig);
    drive(wide, 1'b1, blk, hin);
    check("ready_idle", 512'(get_br(wide)), 512'(1'b1));
    @(negedge clk);
    drive(wide, 1'b0, ~blk, ~hin);
    check("busy_after_accept", 512'(get_br(wide)), 512'(1'b0));
    wait_digest(wide, dig);
  endtask

  task automatic take_digest(input bit wide);
    logic [511:0] held;
    held = get_dg(wide);
    if (wide) dr64 = 1'b1;
    else      dr32 = 1'b1;
    @(negedge clk);
    dr32 = 1'b0;
    dr64 = 1'b0;
    check("ready_after_take", 512'(get_br(wide)), 512'(1'b1));
    check("valid_after_take", 512'(get_dv(wide)), 512'(1'b0));
    check("digest_held", get_dg(wide), held);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] d, d1, blk1, blk2;
    bit bp_stable, bp_valid, bp_ready, bp_noacc, seen;
    int n;

    rst  = 1'b1;
    dr32 = 1'b0;
    dr64 = 1'b0;
    drive(1'b0, 1'b1, {512'd0, {16{32'hdeadbeef}}}, 512'(IV256));
    drive(1'b1, 1'b1, {16{64'h0123456789abcdef}}, IV512);
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready32", 512'(br32), 512'(1'b1));
    check("rst_valid32", 512'(dv32), 512'(1'b0));
    check("rst_digest32", 512'(dg32), 512'd0);
    check("rst_kidx32", 512'(ki32), 512'd0);
    check("rst_ready64", 512'(br64), 512'(1'b1));
    check("rst_valid64", 512'(dv64), 512'(1'b0));
    check("rst_digest64", dg64, 512'd0);
    check("rst_kidx64", 512'(ki64), 512'd0);

    run_block(1'b0, 1024'(ABC_BLK256), 512'(IV256), d);
    check("abc256", d, 512'(ABC_DIG256));
    check("kidx_done32", 512'(ki32), 512'd0);
    take_digest(1'b0);

    run_block(1'b1, ABC_BLK512, IV512, d);
    check("abc512", d, ABC_DIG512);
    take_digest(1'b1);

    blk1 = '0;
    for (int i = 0; i < 14; i++)
      blk1[(15-i)*32 +: 32] = {8'(8'h61 + i), 8'(8'h62 + i),
                               8'(8'h63 + i), 8'(8'h64 + i)};
    blk1[32 +: 32] = 32'h80000000;
    blk2 = {480'd0, 32'h000001c0};

    run_block(1'b0, 1024'(ABC_BLK256), 512'(IV256), d);
    check("abc256_again", d, 512'(ABC_DIG256));
    drive(1'b0, 1'b1, 1024'(blk1), 512'(IV256));
    bp_stable = 1'b1;
    bp_valid  = 1'b1;
    bp_ready  = 1'b1;
    bp_noacc  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dg32 !== ABC_DIG256) bp_stable = 1'b0;
      if (dv32 !== 1'b1) bp_valid = 1'b0;
      if (br32 !== 1'b0) bp_ready = 1'b0;
      if (ki32 !== 7'd0) bp_noacc = 1'b0;
    end
    check("bp_digest_stable", 512'(bp_stable), 512'(1'b1));
    check("bp_valid_held", 512'(bp_valid), 512'(1'b1));
    check("bp_ready_low", 512'(bp_ready), 512'(1'b1));
    check("bp_no_accept", 512'(bp_noacc), 512'(1'b1));
    dr32 = 1'b1;
    @(negedge clk);
    dr32 = 1'b0;
    check("bp_ready_after_take", 512'(br32), 512'(1'b1));
    check("bp_valid_after_take", 512'(dv32), 512'(1'b0));
    @(negedge clk);
    check("bp_accept_next", 512'(br32), 512'(1'b0));
    drive(1'b0, 1'b0, ~1024'(blk1), ~512'(IV256));
    wait_digest(1'b0, d1);
    take_digest(1'b0);
    run_block(1'b0, 1024'(blk2), 512'(d1[255:0]), d);
    check("two_block", d, 512'(TWO_DIG256));
    take_digest(1'b0);

    drive(1'b0, 1'b1, 1024'(ABC_BLK256), 512'(IV256));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0);
    n = 0;
    while (ki32 != 7'd30 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("reach_t30", 512'(ki32), 512'd30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 512'(br32), 512'(1'b1));
    check("abort_valid", 512'(dv32), 512'(1'b0));
    check("abort_digest", 512'(dg32), 512'd0);
    check("abort_kidx", 512'(ki32), 512'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dv32 !== 1'b0) seen = 1'b1;
    end
    check("abort_no_digest", 512'(seen), 512'(1'b0));
    run_block(1'b0, 1024'(ABC_BLK256), 512'(IV256), d);
    check("abc256_after_abort", d, 512'(ABC_DIG256));
    take_digest(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
